// File: rtl/rc4_key_search_ctrl.sv
// RC4 key-search sequencer: walks a key range, drives the fill / KSA /
// decrypt engines in order for each key, and muxes the shared S-memory port
// onto whichever engine is currently active.
module rc4_key_search_ctrl #(
  parameter int unsigned KEY_WIDTH   = 24,
  parameter int unsigned WDOG_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [KEY_WIDTH-1:0] key_lo,
  input  logic [KEY_WIDTH-1:0] key_hi,
  output logic                 engine_rst,
  output logic                 fill_start,
  output logic                 ksa_start,
  output logic                 dm_start,
  input  logic                 fill_done,
  input  logic                 ksa_done,
  input  logic                 dm_done,
  input  logic                 dm_invalid,
  input  logic [7:0]           fill_s_address,
  input  logic [7:0]           ksa_s_address,
  input  logic [7:0]           dm_s_address,
  input  logic [7:0]           fill_s_data,
  input  logic [7:0]           ksa_s_data,
  input  logic [7:0]           dm_s_data,
  input  logic                 fill_s_wren,
  input  logic                 ksa_s_wren,
  input  logic                 dm_s_wren,
  output logic [7:0]           s_address,
  output logic [7:0]           s_data,
  output logic                 s_wren,
  output logic [KEY_WIDTH-1:0] key,
  output logic                 busy,
  output logic                 found,
  output logic                 exhausted,
  output logic                 err_timeout
);

  localparam int unsigned WDW = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(WDOG_CYCLES - 2);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_FILL_GO,
    S_FILL_WAIT,
    S_KSA_GO,
    S_KSA_WAIT,
    S_DM_GO,
    S_DM_WAIT,
    S_NEXT_KEY,
    S_FOUND,
    S_EXHAUSTED
  } state_e;

  state_e               state_q, state_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [KEY_WIDTH-1:0] hi_q, hi_d;
  logic [WDW-1:0]       wdog_q, wdog_d;
  logic                 err_q, err_d;
  logic                 engine_rst_q, engine_rst_d;
  logic                 fill_start_q, fill_start_d;
  logic                 ksa_start_q, ksa_start_d;
  logic                 dm_start_q, dm_start_d;
  logic                 busy_q, busy_d;
  logic                 found_q, found_d;
  logic                 exhausted_q, exhausted_d;
  logic                 abort;
  logic                 wdog_hit;

  assign wdog_hit = (wdog_q == WDOG_LAST);

  // Next-state, key/watchdog update, and registered output decode of the next state
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    hi_d    = hi_q;
    wdog_d  = wdog_q;
    err_d   = err_q;
    abort   = 1'b0;
    if (stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      abort   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_FOUND, S_EXHAUSTED: begin
          if (start) begin
            key_d   = key_lo;
            hi_d    = key_hi;
            err_d   = 1'b0;
            state_d = (key_lo > key_hi) ? S_EXHAUSTED : S_CLR;
          end
        end
        S_CLR: state_d = S_FILL_GO;
        S_FILL_GO: begin
          wdog_d  = '0;
          state_d = S_FILL_WAIT;
        end
        S_FILL_WAIT: begin
          if (fill_done) begin
            state_d = S_KSA_GO;
          end else if (wdog_hit) begin
            err_d   = 1'b1;
            state_d = S_NEXT_KEY;
          end else begin
            wdog_d = wdog_q + WDW'(1);
          end
        end
        S_KSA_GO: begin
          wdog_d  = '0;
          state_d = S_KSA_WAIT;
        end
        S_KSA_WAIT: begin
          if (ksa_done) begin
            state_d = S_DM_GO;
          end else if (wdog_hit) begin
            err_d   = 1'b1;
            state_d = S_NEXT_KEY;
          end else begin
            wdog_d = wdog_q + WDW'(1);
          end
        end
        S_DM_GO: begin
          wdog_d  = '0;
          state_d = S_DM_WAIT;
        end
        S_DM_WAIT: begin
          if (dm_invalid) begin
            state_d = S_NEXT_KEY;
          end else if (dm_done) begin
            state_d = S_FOUND;
          end else if (wdog_hit) begin
            err_d   = 1'b1;
            state_d = S_NEXT_KEY;
          end else begin
            wdog_d = wdog_q + WDW'(1);
          end
        end
        S_NEXT_KEY: begin
          if (key_q == hi_q) begin
            state_d = S_EXHAUSTED;
          end else begin
            key_d   = key_q + KEY_WIDTH'(1);
            state_d = S_CLR;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they line up with the state register
    engine_rst_d = abort || (state_d == S_CLR);
    fill_start_d = (state_d == S_FILL_GO);
    ksa_start_d  = (state_d == S_KSA_GO);
    dm_start_d   = (state_d == S_DM_GO);
    found_d      = (state_d == S_FOUND);
    exhausted_d  = (state_d == S_EXHAUSTED);
    busy_d       = !((state_d == S_IDLE) || (state_d == S_FOUND) || (state_d == S_EXHAUSTED));
  end

  // State and registered outputs; engines are held in reset while reset_n is low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      key_q        <= '0;
      hi_q         <= '0;
      wdog_q       <= '0;
      err_q        <= 1'b0;
      engine_rst_q <= 1'b1;
      fill_start_q <= 1'b0;
      ksa_start_q  <= 1'b0;
      dm_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      found_q      <= 1'b0;
      exhausted_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      hi_q         <= hi_d;
      wdog_q       <= wdog_d;
      err_q        <= err_d;
      engine_rst_q <= engine_rst_d;
      fill_start_q <= fill_start_d;
      ksa_start_q  <= ksa_start_d;
      dm_start_q   <= dm_start_d;
      busy_q       <= busy_d;
      found_q      <= found_d;
      exhausted_q  <= exhausted_d;
    end
  end

  // Zero-latency S-memory port routing from the current state
  always_comb begin
    s_address = '0;
    s_data    = '0;
    s_wren    = 1'b0;
    case (state_q)
      S_FILL_GO, S_FILL_WAIT: begin
        s_address = fill_s_address;
        s_data    = fill_s_data;
        s_wren    = fill_s_wren;
      end
      S_KSA_GO, S_KSA_WAIT: begin
        s_address = ksa_s_address;
        s_data    = ksa_s_data;
        s_wren    = ksa_s_wren;
      end
      S_DM_GO, S_DM_WAIT: begin
        s_address = dm_s_address;
        s_data    = dm_s_data;
        s_wren    = dm_s_wren;
      end
      default: begin
        s_address = '0;
        s_data    = '0;
        s_wren    = 1'b0;
      end
    endcase
  end

  assign engine_rst  = engine_rst_q;
  assign fill_start  = fill_start_q;
  assign ksa_start   = ksa_start_q;
  assign dm_start    = dm_start_q;
  assign busy        = busy_q;
  assign found       = found_q;
  assign exhausted   = exhausted_q;
  assign err_timeout = err_q;
  assign key         = key_q;

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Scoreboard bench for rc4_key_search_ctrl: stub engines, expected event
// queue filled by the stimulus, and a negedge monitor that pops and compares.
module tb_rc4_key_search_ctrl;

  localparam int unsigned KW = 24;
  localparam int unsigned WD = 16;

  localparam logic [2:0] EV_RST  = 3'd0;
  localparam logic [2:0] EV_FILL = 3'd1;
  localparam logic [2:0] EV_KSA  = 3'd2;
  localparam logic [2:0] EV_DM   = 3'd3;
  localparam logic [2:0] EV_FND  = 3'd4;
  localparam logic [2:0] EV_EXH  = 3'd5;

  typedef struct packed {
    logic [2:0]    code;
    logic [KW-1:0] key;
    logic          err;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [KW-1:0] key_lo = '0;
  logic [KW-1:0] key_hi = '0;
  logic          engine_rst, fill_start, ksa_start, dm_start;
  logic          fill_done = 1'b0, ksa_done = 1'b0, dm_done = 1'b0, dm_invalid = 1'b0;
  logic [7:0]    s_address, s_data;
  logic          s_wren;
  logic [KW-1:0] key;
  logic          busy, found, exhausted, err_timeout;

  int  fill_cnt = 0, ksa_cnt = 0, dm_cnt = 0;
  bit  ksa_hang = 1'b0;
  bit  accept_en = 1'b0;
  logic [KW-1:0] accept_key = '0;
  bit  in_reset = 1'b1;
  int  n_cmp = 0;
  int  n_err = 0;
  ev_t exp_q[$];
  logic found_prev = 1'b0, exh_prev = 1'b0;

  always #5 clk = ~clk;

  rc4_key_search_ctrl #(.KEY_WIDTH(KW), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .key_lo(key_lo), .key_hi(key_hi),
    .engine_rst(engine_rst), .fill_start(fill_start), .ksa_start(ksa_start), .dm_start(dm_start),
    .fill_done(fill_done), .ksa_done(ksa_done), .dm_done(dm_done), .dm_invalid(dm_invalid),
    .fill_s_address(8'h11), .ksa_s_address(8'h22), .dm_s_address(8'h33),
    .fill_s_data(8'hA1), .ksa_s_data(8'hB2), .dm_s_data(8'hC3),
    .fill_s_wren(1'b1), .ksa_s_wren(1'b0), .dm_s_wren(1'b1),
    .s_address(s_address), .s_data(s_data), .s_wren(s_wren),
    .key(key), .busy(busy), .found(found), .exhausted(exhausted), .err_timeout(err_timeout)
  );

  // Stub engines: done rises three cycles after start, sticky until engine_rst
  always @(posedge clk) begin
    if (engine_rst) begin
      fill_done <= 1'b0; fill_cnt <= 0;
    end else if (fill_start) begin
      fill_cnt <= 3;
    end else if (fill_cnt != 0) begin
      fill_cnt <= fill_cnt - 1;
      if (fill_cnt == 1) fill_done <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (engine_rst) begin
      ksa_done <= 1'b0; ksa_cnt <= 0;
    end else if (ksa_start) begin
      ksa_cnt <= 3;
    end else if (ksa_cnt != 0) begin
      ksa_cnt <= ksa_cnt - 1;
      if (ksa_cnt == 1 && !ksa_hang) ksa_done <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (engine_rst) begin
      dm_done <= 1'b0; dm_invalid <= 1'b0; dm_cnt <= 0;
    end else if (dm_start) begin
      dm_cnt <= 3;
    end else if (dm_cnt != 0) begin
      dm_cnt <= dm_cnt - 1;
      if (dm_cnt == 1) begin
        dm_done    <= 1'b1;
        dm_invalid <= !(accept_en && (key == accept_key));
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [2:0] code, input logic [KW-1:0] k, input logic e);
    ev_t ev;
    ev.code = code; ev.key = k; ev.err = e;
    exp_q.push_back(ev);
  endtask

  task automatic push_key(input logic [KW-1:0] k, input logic e, input int upto);
    push(EV_RST, k, e);
    push(EV_FILL, k, e);
    push(EV_KSA, k, e);
    if (upto > 3) push(EV_DM, k, e);
  endtask

  task automatic observe(input logic [2:0] code);
    ev_t ev;
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL unexpected_event: got code %0d key %0h, required none", code, key);
    end else begin
      ev = exp_q.pop_front();
      check("event_code", 32'(code), 32'(ev.code));
      check("event_key", 32'(key), 32'(ev.key));
      check("event_err", 32'(err_timeout), 32'(ev.err));
    end
  endtask

  // Monitor: pop expected events whenever the DUT presents a pulse or status rise
  always @(negedge clk) begin
    found_prev <= found;
    exh_prev   <= exhausted;
    if (reset_n && !in_reset) begin
      if (engine_rst) observe(EV_RST);
      if (fill_start) observe(EV_FILL);
      if (ksa_start)  observe(EV_KSA);
      if (dm_start)   observe(EV_DM);
      if (found && !found_prev)   observe(EV_FND);
      if (exhausted && !exh_prev) observe(EV_EXH);
      if (fill_start) begin
        check("mux_fill_addr", 32'(s_address), 32'h11);
        check("mux_fill_data", 32'(s_data), 32'hA1);
        check("mux_fill_wren", 32'(s_wren), 32'h1);
      end
      if (ksa_start) begin
        check("mux_ksa_addr", 32'(s_address), 32'h22);
        check("mux_ksa_wren", 32'(s_wren), 32'h0);
      end
      if (dm_start) begin
        check("mux_dm_addr", 32'(s_address), 32'h33);
        check("mux_dm_wren", 32'(s_wren), 32'h1);
      end
      if (engine_rst || found || exhausted) begin
        check("mux_idle_addr", 32'(s_address), 32'h0);
        check("mux_idle_wren", 32'(s_wren), 32'h0);
      end
    end
  end

  task automatic launch(input logic [KW-1:0] lo, input logic [KW-1:0] hi);
    @(negedge clk);
    key_lo = lo; key_hi = hi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    key_lo = 24'h0AAAAA; key_hi = '0;
  endtask

  task automatic wait_end(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (found || exhausted) done = 1'b1;
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL wait_end: got no found/exhausted, required within %0d cycles", budget);
    end
  endtask

  task automatic wait_start(input int sel, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if ((sel == 1 && ksa_start) || (sel == 2 && dm_start)) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL wait_start: got no pulse, required start sel %0d", sel);
    end
  endtask

  task automatic end_test(input logic [KW-1:0] k, input logic e);
    push(EV_RST, k, e);
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    check("stop_busy", 32'(busy), 32'h0);
    check("stop_status", 32'({found, exhausted}), 32'h0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, required finish before 100us");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    int n;
    #2 reset_n = 1'b0;
    #1;
    check("rst_engine_rst", 32'(engine_rst), 32'h1);
    check("rst_outputs", 32'({fill_start, ksa_start, dm_start, busy, found, exhausted, err_timeout, s_wren}), 32'h0);
    check("rst_key", 32'(key), 32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    in_reset = 1'b0;
    #1;
    check("idle_after_rst", 32'({engine_rst, busy, found, exhausted}), 32'h0);

    // Single key, accepted
    accept_en = 1'b1; accept_key = 24'd5;
    push_key(24'd5, 1'b0, 4); push(EV_FND, 24'd5, 1'b0);
    launch(24'd5, 24'd5);
    wait_end(200);
    check("t1_found", 32'(found), 32'h1);
    check("t1_busy", 32'(busy), 32'h0);
    check("t1_key", 32'(key), 32'd5);
    end_test(24'd5, 1'b0);

    // Keys 0-2 rejected, 3 accepted
    accept_key = 24'd3;
    for (int k = 0; k < 4; k++) push_key(KW'(k), 1'b0, 4);
    push(EV_FND, 24'd3, 1'b0);
    launch(24'd0, 24'd3);
    wait_end(300);
    check("t2_found", 32'(found), 32'h1);
    check("t2_key", 32'(key), 32'd3);
    end_test(24'd3, 1'b0);

    // All rejected
    accept_en = 1'b0;
    for (int k = 0; k < 3; k++) push_key(KW'(k), 1'b0, 4);
    push(EV_EXH, 24'd2, 1'b0);
    launch(24'd0, 24'd2);
    wait_end(300);
    check("t3_exhausted", 32'(exhausted), 32'h1);
    check("t3_key", 32'(key), 32'd2);
    end_test(24'd2, 1'b0);

    // Empty range: exhausted one cycle after start, no engine activity
    push(EV_EXH, 24'd7, 1'b0);
    launch(24'd7, 24'd3);
    check("t3b_exhausted", 32'(exhausted), 32'h1);
    check("t3b_key", 32'(key), 32'd7);
    check("t3b_busy", 32'(busy), 32'h0);
    end_test(24'd7, 1'b0);

    // Top of key space: no wrap
    push_key(24'hFFFFFE, 1'b0, 4);
    push_key(24'hFFFFFF, 1'b0, 4);
    push(EV_EXH, 24'hFFFFFF, 1'b0);
    launch(24'hFFFFFE, 24'hFFFFFF);
    wait_end(300);
    check("t4_exhausted", 32'(exhausted), 32'h1);
    check("t4_key", 32'(key), 32'hFFFFFF);
    end_test(24'hFFFFFF, 1'b0);

    // Watchdog: KSA never completes
    ksa_hang = 1'b1;
    push_key(24'd0, 1'b0, 3);
    push_key(24'd1, 1'b1, 3);
    push(EV_EXH, 24'd1, 1'b1);
    launch(24'd0, 24'd1);
    wait_start(1, 50);
    n = 0;
    for (int i = 0; i < 40 && !err_timeout; i++) begin
      @(negedge clk);
      n++;
    end
    check("t5_wdog_cycles", 32'(n), 32'd16);
    check("t5_key_after_timeout", 32'(key), 32'd0);
    wait_end(200);
    check("t5_exhausted", 32'(exhausted), 32'h1);
    check("t5_err", 32'(err_timeout), 32'h1);
    check("t5_key", 32'(key), 32'd1);
    end_test(24'd1, 1'b1);
    ksa_hang = 1'b0;

    // Stop during KSA_WAIT
    push_key(24'd9, 1'b0, 3);
    push(EV_RST, 24'd9, 1'b0);
    launch(24'd9, 24'd9);
    wait_start(1, 50);
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_engine_rst", 32'(engine_rst), 32'h1);
    @(negedge clk);
    check("t6_engine_rst_drop", 32'(engine_rst), 32'h0);
    check("t6_idle", 32'({busy, found, exhausted}), 32'h0);

    // Asynchronous reset during DM_WAIT
    accept_en = 1'b1; accept_key = 24'd4;
    push_key(24'd4, 1'b0, 4);
    launch(24'd4, 24'd4);
    wait_start(2, 50);
    @(negedge clk);
    in_reset = 1'b1;
    reset_n = 1'b0;
    #1;
    check("t7_rst_engine_rst", 32'(engine_rst), 32'h1);
    check("t7_rst_outputs", 32'({fill_start, ksa_start, dm_start, busy, found, exhausted, err_timeout, s_wren}), 32'h0);
    check("t7_rst_key", 32'(key), 32'h0);
    check("t7_rst_addr", 32'(s_address), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    in_reset = 1'b0;
    #1;
    check("t7_release_idle", 32'({engine_rst, busy, found, exhausted}), 32'h0);
    check("t7_release_key", 32'(key), 32'h0);

    repeat (3) @(negedge clk);
    check("scoreboard_leftover", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
